axi_stream_packet_arbiter: RTL and testbench
============================================

// Module: axi_stream_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter multiplexing N_REQ AXI4-Stream requesters onto one shared
//  downstream stream (typically a single 512->256 width converter instance). Grant locks for a whole
//  packet (until tlast beat accepted); no beat interleaving. Output goes through an internal 2-entry
//  skid slice to break the tready path; m_tid carries the source index for downstream demux/accounting.
// PARAMETERS
//  N_REQ       4    number of requesters, 2..16
//  DATA_WIDTH  512  tdata width in bits, multiple of 8; keep width KEEP_W = DATA_WIDTH/8
//  ID_W        $clog2(N_REQ)  width of grant/tid index (derived, not overridable)
// PORTS
//  clk          in   1                  clock, all logic rising-edge
//  rst_n        in   1                  asynchronous active-low reset
//  s_tvalid     in   N_REQ              per-requester tvalid
//  s_tready     out  N_REQ              per-requester tready; at most one bit high per cycle
//  s_tdata      in   N_REQ*DATA_WIDTH   requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tkeep      in   N_REQ*KEEP_W       requester i at [i*KEEP_W +: KEEP_W]
//  s_tlast      in   N_REQ              per-requester tlast
//  m_tvalid     out  1                  shared output stream valid
//  m_tready     in   1                  shared output stream ready
//  m_tdata      out  DATA_WIDTH         output data
//  m_tkeep      out  KEEP_W             output keep
//  m_tlast      out  1                  output last
//  m_tid        out  ID_W               index of requester owning the beat
//  busy         out  1                  1 while a grant is locked (LOCKED state)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, grant=0, skid empty -> m_tvalid=0, s_tready=0,
//   busy=0, m_tid=0, m_tdata/m_tkeep/m_tlast=0. Reset mid-packet discards skid contents and lock.
//  FSM IDLE: if any s_tvalid, pick first valid index scanning rr_ptr, rr_ptr+1, ... mod N_REQ;
//   register grant, go LOCKED next edge. s_tready all 0 in IDLE (1-cycle arbitration bubble).
//  FSM LOCKED: s_tready[grant] = skid has free entry; other s_tready=0. Beat accepted when
//   s_tvalid[grant] && s_tready[grant]; pushed into skid with tid=grant.
//   Accepted beat with s_tlast=1 -> rr_ptr <= (grant+1) mod N_REQ, go IDLE same edge.
//  Lock holds while s_tvalid[grant] is low mid-packet; other requesters never granted until tlast.
//  Single-beat packet: one LOCKED cycle minimum, then IDLE; back-to-back packets cost 1 bubble.
//  Skid slice: 2 entries, registered output; m_tvalid = entry 0 valid. Latency: beat accepted at
//   edge k appears on m_* after edge k (visible cycle k+1). Full throughput 1 beat/cycle while
//   m_tready=1. s_tready depends only on registered skid occupancy (no comb path from m_tready).
//  m_* stable while m_tvalid=1 && m_tready=0 (AXI rule). Pop on m_tvalid && m_tready.
//  Simultaneous push and pop on full skid impossible (s_tready=0 when full); push+pop at occupancy 1
//   keeps occupancy 1.
//  rr_ptr wraps N_REQ-1 -> 0. Non-power-of-two N_REQ: indices >= N_REQ never granted.
//  tkeep passed through unmodified; no check of tkeep/tlast consistency.
// STRUCTURE
//  libstf_axi_pkg (shared package): typedef enum {ARB_IDLE, ARB_LOCKED} arb_state_t;
//   function rr_pick(req, ptr) returning first set index from ptr with wrap.
//  Sub-module: axi_skid_slice #(PAYLOAD_W) - 2-entry register slice, payload {tid,tlast,tkeep,tdata};
//   reusable in front of width converters elsewhere.
//  Top: FSM + rr_ptr + grant register + input mux; ~200 lines total.
// TESTING
//  1 Req0 only, 3-beat pkt (tlast on beat 3), m_tready=1 -> grant 1 cycle after s_tvalid,
//    m_tid=0, beats out in order 1 cycle after accept, busy low after beat 3.
//  2 All 4 req valid, 2-beat pkts continuously -> packet order 0,1,2,3,0; no tid change mid-packet;
//    1 idle bubble between packets.
//  3 Req2 5-beat pkt, m_tready=0 for 5 cycles after beat 2 -> skid fills (2), s_tready[2]=0,
//    m_* stable; all 5 beats delivered, none duplicated or lost.
//  4 Req1 and Req3 streaming single-beat pkts -> grants alternate 1,3,1,3; m_tlast=1 every beat.
//  5 Assert rst_n=0 mid-packet on req0 -> m_tvalid, s_tready, busy drop without clock edge;
//    after release with req3 and req0 valid -> req0 granted first (rr_ptr=0).
//  6 Req0 drops s_tvalid 4 cycles mid-packet while req1 valid -> busy stays 1, s_tready[1]=0,
//    req1 granted only after req0 tlast accepted.

Source files
------------

// File: rtl/axi_stream_packet_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter: arbitration state encoding and
// the round-robin pick used to choose the next packet owner.
package axi_stream_packet_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int RR_MAX_REQ = 16;

  // First set bit of req scanning ptr, ptr+1, ... with wrap at n (n <= RR_MAX_REQ, ptr < n).
  function automatic logic [3:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [4:0] idx;
    logic [3:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < RR_MAX_REQ; off++) begin
      idx = {1'b0, ptr} + 5'(off);
      if (idx >= 5'(n)) idx = idx - 5'(n);
      if ((off < n) && !found && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_stream_packet_arbiter_skid.sv
// Two-entry register slice. Output is always taken from entry 0; in_ready is a pure
// function of the registered occupancy so nothing combinational crosses from out_ready.
module axi_skid_slice #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [PAYLOAD_W-1:0] entry0;
  logic [PAYLOAD_W-1:0] entry1;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;

  assign in_ready    = (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign out_payload = entry0;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            entry0 <= in_payload;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          // Push and pop together replace the head and keep occupancy at one.
          if (push && pop) begin
            entry0 <= in_payload;
          end else if (push) begin
            entry1 <= in_payload;
            count  <= 2'd2;
          end else if (pop) begin
            count  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            entry0 <= entry1;
            count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-granular round-robin arbiter: one requester owns the shared stream from grant
// until its tlast beat is accepted; beats leave through a two-entry skid slice tagged with m_tid.
module axi_stream_packet_arbiter
  import axi_stream_packet_arbiter_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 512,
  localparam int KEEP_W     = DATA_WIDTH / 8,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            s_tvalid,
  output logic [N_REQ-1:0]            s_tready,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_REQ*KEEP_W-1:0]     s_tkeep,
  input  logic [N_REQ-1:0]            s_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic [KEEP_W-1:0]           m_tkeep,
  output logic                        m_tlast,
  output logic [ID_W-1:0]             m_tid,
  output logic                        busy
);

  localparam int PAYLOAD_W = ID_W + 1 + KEEP_W + DATA_WIDTH;

  // Handshake: a beat moves on any interface only in a cycle where valid && ready are both
  // high at the rising edge; valid and payload never depend on ready of the same interface.

  arb_state_t            state;
  logic [ID_W-1:0]       grant;
  logic [ID_W-1:0]       rr_ptr;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  accept;

  logic                  skid_in_ready;
  logic                  skid_out_valid;
  logic [PAYLOAD_W-1:0]  skid_in_payload;
  logic [PAYLOAD_W-1:0]  skid_out_payload;

  always_comb begin
    sel_valid = s_tvalid[grant];
    sel_last  = s_tlast[grant];
    sel_data  = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
    sel_keep  = s_tkeep[grant*KEEP_W +: KEEP_W];
  end

  // Only the owner ever sees ready, and only while the lock is held.
  always_comb begin
    s_tready = '0;
    if (state == ARB_LOCKED) s_tready[grant] = skid_in_ready;
  end

  assign accept          = (state == ARB_LOCKED) && sel_valid && skid_in_ready;
  assign skid_in_payload = {grant, sel_last, sel_keep, sel_data};
  assign busy            = (state == ARB_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|s_tvalid) begin
            grant <= ID_W'(rr_pick(RR_MAX_REQ'(s_tvalid), 4'(rr_ptr), N_REQ));
            state <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (accept && sel_last) begin
            rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  axi_skid_slice #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (accept),
    .in_ready   (skid_in_ready),
    .in_payload (skid_in_payload),
    .out_valid  (skid_out_valid),
    .out_ready  (m_tready),
    .out_payload(skid_out_payload)
  );

  assign m_tvalid = skid_out_valid;
  assign {m_tid, m_tlast, m_tkeep, m_tdata} = skid_out_payload;

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed bench for the packet arbiter: per-requester beat queues drive the inputs,
// a negedge monitor captures delivered beats, and each scenario task checks its own results.
module tb_axi_stream_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } out_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            busy;

  beat_t        src_q[N][$];
  logic [N-1:0] hold     = '0;
  logic [N-1:0] acc_mask = '0;
  out_t         got_q[$];
  int           got_cyc[$];
  out_t         exp_q[$];
  int           cyc      = 0;
  int           n_checks = 0;
  int           n_pass   = 0;

  axi_stream_packet_arbiter #(
    .N_REQ     (N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tid   (m_tid),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  function automatic logic [DW-1:0] dv(input int s, input int p, input int b);
    return {8'hD0 | 8'(s), 8'(p), 8'(b), 8'h5A};
  endfunction

  function automatic out_t eb(input int s, input int p, input int b, input int nb);
    out_t o;
    o.tid  = IW'(s);
    o.last = (b == nb - 1);
    o.keep = (b == nb - 1) ? 4'h3 : 4'hF;
    o.data = dv(s, p, b);
    return o;
  endfunction

  function automatic void drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_q[i][0].data;
        s_tkeep[i*KW +: KW]  = src_q[i][0].keep;
        s_tlast[i]           = src_q[i][0].last;
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tkeep[i*KW +: KW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endfunction

  task automatic push_pkt(input int s, input int p, input int nb);
    beat_t bt;
    for (int b = 0; b < nb; b++) begin
      bt.data = dv(s, p, b);
      bt.keep = (b == nb - 1) ? 4'h3 : 4'hF;
      bt.last = (b == nb - 1);
      src_q[s].push_back(bt);
    end
  endtask

  function automatic void flush_sources();
    for (int i = 0; i < N; i++) src_q[i].delete();
    hold     = '0;
    acc_mask = '0;
    drive_inputs();
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < N; i++)
      if (acc_mask[i] && src_q[i].size() > 0) src_q[i].delete(0);
    acc_mask = '0;
    drive_inputs();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    out_t o;
    acc_mask = s_tvalid & s_tready;
    if (rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      o = {m_tid, m_tlast, m_tkeep, m_tdata};
      got_q.push_back(o);
      got_cyc.push_back(cyc);
    end
  end

  task automatic reset_dut();
    @(posedge clk); #2;
    rst_n    = 1'b0;
    m_tready = 1'b1;
    flush_sources();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({m_tvalid, busy, s_tready} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want %b", {m_tvalid, busy, s_tready}, 6'b0);
    else n_pass++;
    n_checks++;
    if ({m_tid, m_tlast, m_tkeep, m_tdata} !== '0)
      $display("FAIL reset_payload: got %h want 0", {m_tid, m_tlast, m_tkeep, m_tdata});
    else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single_req();
    bit ok;
    int c0;
    reset_dut();
    push_pkt(0, 0, 3);
    drive_inputs();
    c0 = cyc;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, s_tready} !== 5'b0_0000)
      $display("FAIL t1_bubble: got %b want %b", {busy, s_tready}, 5'b0_0000);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, s_tready} !== 5'b1_0001)
      $display("FAIL t1_grant: got %b want %b", {busy, s_tready}, 5'b1_0001);
    else n_pass++;
    wait_out(3, ok);
    n_checks++;
    if (!ok) $display("FAIL t1_timeout: got %0d beats want 3", got_q.size());
    else n_pass++;
    for (int b = 0; b < 3; b++) exp_q.push_back(eb(0, 0, b, 3));
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k])
        $display("FAIL t1_beat%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : '0, exp_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (got_cyc.size() < 3 || got_cyc[0] != c0 + 2 || got_cyc[2] != c0 + 4)
      $display("FAIL t1_latency: got first/last cycle %0d/%0d want %0d/%0d",
               (got_cyc.size() > 0) ? got_cyc[0] - c0 : -1,
               (got_cyc.size() > 2) ? got_cyc[2] - c0 : -1, 2, 4);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL t1_busy_end: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    push_pkt(0, 0, 2);
    push_pkt(1, 0, 2);
    push_pkt(2, 0, 2);
    push_pkt(3, 0, 2);
    push_pkt(0, 1, 2);
    drive_inputs();
    for (int p = 0; p < 5; p++)
      for (int b = 0; b < 2; b++) exp_q.push_back(eb(order[p], (p == 4) ? 1 : 0, b, 2));
    wait_out(10, ok);
    n_checks++;
    if (!ok) $display("FAIL t2_timeout: got %0d beats want 10", got_q.size());
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k])
        $display("FAIL t2_beat%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : '0, exp_q[k]);
      else n_pass++;
    end
    for (int p = 0; p < 5; p++) begin
      n_checks++;
      if (got_cyc.size() < 2 * p + 2 || got_cyc[2*p+1] - got_cyc[2*p] != 1)
        $display("FAIL t2_intra_gap%0d: got %0d want 1", p,
                 (got_cyc.size() >= 2 * p + 2) ? got_cyc[2*p+1] - got_cyc[2*p] : -1);
      else n_pass++;
    end
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (got_cyc.size() < 2 * p + 3 || got_cyc[2*p+2] - got_cyc[2*p+1] != 2)
        $display("FAIL t2_bubble%0d: got %0d want 2", p,
                 (got_cyc.size() >= 2 * p + 3) ? got_cyc[2*p+2] - got_cyc[2*p+1] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    reset_dut();
    push_pkt(2, 0, 5);
    drive_inputs();
    for (int b = 0; b < 5; b++) exp_q.push_back(eb(2, 0, b, 5));
    wait_out(2, ok);
    n_checks++;
    if (!ok) $display("FAIL t3_timeout_a: got %0d beats want 2", got_q.size());
    else n_pass++;
    @(posedge clk); #2;
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({m_tvalid, m_tid, m_tdata} !== {1'b1, 2'd2, dv(2, 0, 2)})
        $display("FAIL t3_stable%0d: got %h want %h", k, {m_tvalid, m_tid, m_tdata},
                 {1'b1, 2'd2, dv(2, 0, 2)});
      else n_pass++;
      n_checks++;
      if (s_tready !== ((k == 0) ? 4'b0100 : 4'b0000))
        $display("FAIL t3_ready%0d: got %b want %b", k, s_tready, (k == 0) ? 4'b0100 : 4'b0000);
      else n_pass++;
    end
    @(posedge clk); #2;
    m_tready = 1'b1;
    wait_out(5, ok);
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 5) $display("FAIL t3_count: got %0d want 5", got_q.size());
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k])
        $display("FAIL t3_beat%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : '0, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_alternate_single();
    bit ok;
    reset_dut();
    push_pkt(1, 0, 1);
    push_pkt(1, 1, 1);
    push_pkt(3, 0, 1);
    push_pkt(3, 1, 1);
    drive_inputs();
    exp_q.push_back(eb(1, 0, 0, 1));
    exp_q.push_back(eb(3, 0, 0, 1));
    exp_q.push_back(eb(1, 1, 0, 1));
    exp_q.push_back(eb(3, 1, 0, 1));
    wait_out(4, ok);
    n_checks++;
    if (!ok) $display("FAIL t4_timeout: got %0d beats want 4", got_q.size());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k])
        $display("FAIL t4_beat%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : '0, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    reset_dut();
    push_pkt(1, 0, 1);
    drive_inputs();
    wait_out(1, ok);
    @(posedge clk); #2;
    push_pkt(0, 0, 4);
    drive_inputs();
    wait_out(2, ok);
    n_checks++;
    if (!ok) $display("FAIL t5_timeout_a: got %0d beats want 2", got_q.size());
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if ({busy, m_tvalid} !== 2'b11) $display("FAIL t5_pre: got %b want 11", {busy, m_tvalid});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_tvalid, busy, s_tready} !== 6'b0)
      $display("FAIL t5_async: got %b want %b", {m_tvalid, busy, s_tready}, 6'b0);
    else n_pass++;
    flush_sources();
    repeat (2) @(posedge clk);
    #2;
    got_q.delete();
    got_cyc.delete();
    rst_n = 1'b1;
    push_pkt(3, 1, 1);
    push_pkt(0, 2, 1);
    drive_inputs();
    exp_q.delete();
    exp_q.push_back(eb(0, 2, 0, 1));
    exp_q.push_back(eb(3, 1, 0, 1));
    wait_out(2, ok);
    n_checks++;
    if (!ok) $display("FAIL t5_timeout_b: got %0d beats want 2", got_q.size());
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k])
        $display("FAIL t5_beat%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : '0, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_lock_hold();
    bit ok;
    reset_dut();
    push_pkt(0, 0, 4);
    drive_inputs();
    wait_out(2, ok);
    @(posedge clk); #2;
    hold[0] = 1'b1;
    push_pkt(1, 0, 1);
    drive_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({busy, s_tready} !== 5'b1_0001)
        $display("FAIL t6_hold%0d: got %b want %b", k, {busy, s_tready}, 5'b1_0001);
      else n_pass++;
    end
    n_checks++;
    if (got_q.size() != 3) $display("FAIL t6_held_count: got %0d want 3", got_q.size());
    else n_pass++;
    @(posedge clk); #2;
    hold[0] = 1'b0;
    drive_inputs();
    for (int b = 0; b < 4; b++) exp_q.push_back(eb(0, 0, b, 4));
    exp_q.push_back(eb(1, 0, 0, 1));
    wait_out(5, ok);
    n_checks++;
    if (!ok) $display("FAIL t6_timeout: got %0d beats want 5", got_q.size());
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k])
        $display("FAIL t6_beat%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : '0, exp_q[k]);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_backpressure();
    test_alternate_single();
    test_reset_mid_packet();
    test_lock_hold();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
